sar_search_ctrl: RTL and testbench
==================================

# sar_search_ctrl

Successive-approximation search controller: the initiating side of the magnitude-comparator interface. It drives a W-bit guess onto a comparator's B operand, reads the comparator's less/equal/greater flags against an unknown target on the A operand, and binary-searches until equality. The block sits beside the combinational comparator. It returns the recovered target value, or flags an error when the comparator answers are inconsistent.

## Interface
Parameters:
- W, default 3: operand width; search range 0 .. 2^W-1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a search; accepted only in IDLE.
- lt  in  1  comparator L flag: target < guess.
- eq  in  1  comparator E flag: target == guess.
- gt  in  1  comparator G flag: target > guess.
- guess  out  W  registered probe value driven to the comparator B input.
- busy  out  1  high while in PROBE.
- done  out  1  one-cycle pulse at completion.
- found  out  1  valid with done; held until the next accepted start. Target recovered.
- err  out  1  valid with done; held until the next accepted start. Inconsistent or illegal flags.
- result  out  W  recovered target, valid when found=1; held until the next accepted start.

## Operation
- State machine: IDLE, PROBE, DONE.
- Internal registers are lo and hi, each W bits.
- The midpoint is computed at W+1 bits as mid = (lo + hi) >> 1, so the sum has no overflow.

IDLE:
- On start=1: lo<=0, hi<=2^W-1, guess<=2^(W-1)-1, found<=0, err<=0, result<=0, go to PROBE.
- Otherwise hold all outputs.

PROBE: flags are sampled every cycle against the current guess. Exactly one of lt/eq/gt must be high.
- eq: result<=guess, found<=1, go to DONE.
- lt with guess==lo: err<=1, go to DONE (empty interval).
- lt otherwise: hi<=guess-1, guess<=mid(lo, guess-1).
- gt with guess==hi: err<=1, go to DONE (empty interval, covers guess==2^W-1).
- gt otherwise: lo<=guess+1, guess<=mid(guess+1, hi).
- Zero flags high or more than one flag high: err<=1, go to DONE.

DONE:
- done=1 for exactly this cycle; busy=0.
- Next edge returns to IDLE unconditionally.
- start is ignored here.

Other rules:
- start is ignored in PROBE and DONE; there is no queuing.
- guess is never updated outside IDLE-accept and PROBE; it holds its last value in DONE and IDLE.
- Flags are ignored in IDLE and DONE.
- With consistent answers the search ends with found=1 within W+1 probes.
- err can only occur from illegal flag combinations, or from a target that changes mid-search.

## Timing
- Reset values: state=IDLE, guess=0, busy=0, done=0, found=0, err=0, result=0, lo=0, hi=0.
- Reset asserted mid-search aborts immediately. No done pulse is produced, and a fresh start is required after release.
- Cycle 0: start sampled high in IDLE.
- Cycle 1: first PROBE cycle; guess=2^(W-1)-1, busy=1.
- Each PROBE cycle consumes one comparator answer; the comparator is combinational, so flags are valid in the same cycle as guess.
- A search resolved on probe k: done=1 in cycle k+1, busy=0 in that cycle, IDLE in cycle k+2.
- The earliest next accepted start is in cycle k+2. Total start-to-start period is k+2 cycles.
- Latency bounds: found in 1..W+1 probes.

## Test plan
All scenarios use W=3 with an ideal comparator model (target on A, guess on B) unless stated.
- Target 5: guesses 3(gt), 5(eq) -> done in cycle 3, found=1, result=5, err=0.
- Target 7: guesses 3, 5, 6, 7 -> done in cycle 5, found=1, result=7. Target 0: guesses 3, 1, 0 -> done in cycle 4, result=0.
- Sweep targets 0..7 back-to-back, with start asserted in the first IDLE cycle each time -> every result equals target, probe count ≤4, busy low only in DONE/IDLE.
- Illegal flags: force lt=1, gt=1 on probe 1 -> done in cycle 2, err=1, found=0. Force all flags 0 on probe 2 -> err=1.
- Target changes from 7 to 2 after probe 3 (guess=6): guess 7 answered lt with lo=7 -> err=1. Separately, force gt at guess=7 -> err=1, no wrap to 0.
- Reset and start handling:
  - Assert rst during probe 2 -> all outputs 0 asynchronously, no done pulse; a new search for target 4 then completes normally.
  - start held high through PROBE/DONE -> ignored until IDLE.

Source files
------------

// File: rtl/sar_search_ctrl.sv
// ============================================================================
// Module   : sar_search_ctrl
// Brief    : Successive-approximation search controller. It binary-searches a
//            comparator target by probing with a registered guess.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_search_ctrl #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         lt,
  input  logic         eq,
  input  logic         gt,
  output logic [W-1:0] guess,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         err,
  output logic [W-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [W-1:0] c_max   = {W{1'b1}};
  localparam logic [W-1:0] c_first = c_max >> 1;

  state_t         state_q, state_d;
  logic [W-1:0]   guess_q, guess_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   result_q, result_d;
  logic           found_q, found_d;
  logic           err_q, err_d;

  // The sum is formed one bit wider so that lo + hi cannot overflow.
  function automatic logic [W-1:0] mid_of(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return W'(s >> 1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      guess_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = c_max;
          guess_d  = c_first;
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
          state_d  = PROBE;
        end
      end

      PROBE: begin
        case ({lt, eq, gt})
          3'b010: begin
            result_d = guess_q;
            found_d  = 1'b1;
            state_d  = DONE;
          end
          3'b100: begin
            // An lt answer at the lower bound leaves an empty interval.
            if (guess_q == lo_q) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              hi_d    = guess_q - 1'b1;
              guess_d = mid_of(lo_q, guess_q - 1'b1);
            end
          end
          3'b001: begin
            if (guess_q == hi_q) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              lo_d    = guess_q + 1'b1;
              guess_d = mid_of(guess_q + 1'b1, hi_q);
            end
          end
          default: begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        endcase
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign guess  = guess_q;
  assign result = result_q;
  assign found  = found_q;
  assign err    = err_q;
  assign busy   = (state_q == PROBE);
  assign done   = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_sar_search_ctrl.sv
// ============================================================================
// Module   : tb_sar_search_ctrl
// Brief    : Self-checking bench for sar_search_ctrl with an ideal comparator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sar_search_ctrl;

  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic         start;
  logic         lt, eq, gt;
  logic [W-1:0] guess;
  logic         busy, done, found, err;
  logic [W-1:0] result;

  int           cur_tgt;
  bit           inj_active;
  logic [2:0]   inj_flags;

  int           n_cmp;
  int           n_bad;

  int           exp_g [1:16];
  int           m_n;
  bit           m_found;
  bit           m_err;
  int           m_res;

  typedef struct {
    int         t1;
    int         t2;
    int         chg;
    int         injp;
    logic [2:0] injf;
    int         n;
    bit         f;
    bit         e;
    int         r;
  } vec_t;

  vec_t tbl [11];

  sar_search_ctrl #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .lt     (lt),
    .eq     (eq),
    .gt     (gt),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal comparator with target on A and guess on B, unless overridden.
  always_comb begin
    if (inj_active) begin
      {lt, eq, gt} = inj_flags;
    end else begin
      lt = (cur_tgt <  int'(guess));
      eq = (cur_tgt == int'(guess));
      gt = (cur_tgt >  int'(guess));
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Interval-halving reference over plain integers.
  task automatic model_run(input int t1, input int t2, input int chg,
                           input int injp, input logic [2:0] injf);
    int lo, hi, g, tg;
    logic [2:0] fl;
    lo = 0; hi = (1 << W) - 1; g = (lo + hi) / 2;
    m_n = 0; m_found = 0; m_err = 0; m_res = 0;
    for (int k = 1; k <= 16; k++) begin
      tg = (chg != 0 && k > chg) ? t2 : t1;
      exp_g[k] = g;
      m_n = k;
      fl = (k == injp) ? injf : {tg < g, tg == g, tg > g};
      if (fl == 3'b010) begin
        m_found = 1; m_res = g; break;
      end else if (fl == 3'b100) begin
        if (g == lo) begin m_err = 1; break; end
        hi = g - 1; g = (lo + hi) / 2;
      end else if (fl == 3'b001) begin
        if (g == hi) begin m_err = 1; break; end
        lo = g + 1; g = (lo + hi) / 2;
      end else begin
        m_err = 1; break;
      end
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge of the
  // IDLE cycle following DONE.
  task automatic run_search(input string nm, input vec_t v);
    int  probes;
    int  last_g;
    bit  timed_out;
    model_run(v.t1, v.t2, v.chg, v.injp, v.injf);
    start = 1'b1; cur_tgt = v.t1; inj_flags = v.injf; inj_active = 1'b0;
    @(negedge clk);
    start = 1'b0;
    probes = 0; last_g = 0; timed_out = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (busy) begin
        probes++;
        if (probes <= 16) chk({nm, " guess"}, int'(guess), exp_g[probes]);
        last_g     = int'(guess);
        cur_tgt    = (v.chg != 0 && probes > v.chg) ? v.t2 : v.t1;
        inj_active = (probes == v.injp);
        @(negedge clk);
      end else begin
        timed_out = 1'b0;
        break;
      end
    end
    inj_active = 1'b0;
    if (timed_out) begin
      chk({nm, " timeout"}, 1, 0);
      rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
      return;
    end
    chk({nm, " probes"}, probes, v.n);
    chk({nm, " done"},   int'(done), 1);
    chk({nm, " found"},  int'(found), int'(v.f));
    chk({nm, " err"},    int'(err), int'(v.e));
    chk({nm, " result"}, int'(result), v.r);
    chk({nm, " guess_hold"}, int'(guess), last_g);
    @(negedge clk);
    chk({nm, " idle_done"}, int'(done), 0);
    chk({nm, " idle_busy"}, int'(busy), 0);
    chk({nm, " held_found"},  int'(found), int'(v.f));
    chk({nm, " held_result"}, int'(result), v.r);
  endtask

  initial begin
    vec_t        v;
    logic [2:0]  illegal [5];
    bit          seen;

    n_cmp = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; cur_tgt = 0; inj_active = 1'b0; inj_flags = 3'b000;
    illegal = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    //          t1  t2 chg injp injf    n  f  e  r
    tbl[0]  = '{ 5,  0, 0, 0, 3'b000,  2, 1, 0, 5};
    tbl[1]  = '{ 7,  0, 0, 0, 3'b000,  4, 1, 0, 7};
    tbl[2]  = '{ 0,  0, 0, 0, 3'b000,  3, 1, 0, 0};
    tbl[3]  = '{ 3,  0, 0, 0, 3'b000,  1, 1, 0, 3};
    tbl[4]  = '{ 6,  0, 0, 1, 3'b101,  1, 0, 1, 0};
    tbl[5]  = '{ 5,  0, 0, 2, 3'b000,  2, 0, 1, 0};
    tbl[6]  = '{ 8,  0, 0, 0, 3'b000,  4, 0, 1, 0};
    tbl[7]  = '{ 7,  2, 3, 0, 3'b000,  4, 0, 1, 0};
    tbl[8]  = '{-1,  0, 0, 0, 3'b000,  3, 0, 1, 0};
    tbl[9]  = '{ 1,  0, 0, 0, 3'b000,  2, 1, 0, 1};
    tbl[10] = '{ 2,  0, 0, 0, 3'b000,  3, 1, 0, 2};

    @(negedge clk);
    chk("rst guess",  int'(guess), 0);
    chk("rst busy",   int'(busy), 0);
    chk("rst done",   int'(done), 0);
    chk("rst found",  int'(found), 0);
    chk("rst err",    int'(err), 0);
    chk("rst result", int'(result), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_search($sformatf("tbl%0d", i), tbl[i]);

    // Back-to-back sweep of every target.
    for (int t = 0; t < (1 << W); t++) begin
      model_run(t, 0, 0, 0, 3'b000);
      chk($sformatf("sweep%0d bound", t), int'(m_n <= W + 1), 1);
      v = '{t, 0, 0, 0, 3'b000, m_n, m_found, m_err, m_res};
      run_search($sformatf("sweep%0d", t), v);
    end

    // Asynchronous reset during probe 2 aborts without a done pulse.
    start = 1'b1; cur_tgt = 1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("abort in_probe", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("abort guess",  int'(guess), 0);
    chk("abort busy",   int'(busy), 0);
    chk("abort done",   int'(done), 0);
    chk("abort found",  int'(found), 0);
    chk("abort err",    int'(err), 0);
    chk("abort result", int'(result), 0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("abort quiet", int'(seen), 0);
    run_search("after_abort", '{4, 0, 0, 0, 3'b000, 3, 1, 0, 4});

    // start held high through PROBE and DONE is only taken again in IDLE.
    model_run(6, 0, 0, 0, 3'b000);
    start = 1'b1; cur_tgt = 6;
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("hold probe%0d busy", k), int'(busy), 1);
      chk($sformatf("hold probe%0d guess", k), int'(guess), exp_g[k]);
      @(negedge clk);
    end
    chk("hold done",   int'(done), 1);
    chk("hold result", int'(result), 6);
    @(negedge clk);
    chk("hold idle busy", int'(busy), 0);
    chk("hold idle done", int'(done), 0);
    @(negedge clk);
    start = 1'b0;
    chk("hold restart busy",  int'(busy), 1);
    chk("hold restart guess", int'(guess), 3);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk("hold restart done", int'(seen), 1);
    @(negedge clk);

    // Randomised targets with occasional illegal flag injection.
    for (int i = 0; i < 40; i++) begin
      int         t, p;
      logic [2:0] f;
      t = int'($urandom_range(0, (1 << W) - 1));
      p = 0; f = 3'b000;
      if ($urandom_range(0, 3) == 0) begin
        p = int'($urandom_range(1, W + 1));
        f = illegal[$urandom_range(0, 4)];
      end
      model_run(t, 0, 0, p, f);
      v = '{t, 0, 0, p, f, m_n, m_found, m_err, m_res};
      run_search($sformatf("rand%0d", i), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
